alu_issue_seq: RTL
==================

# alu_issue_seq

Sequencer directly upstream of the integer ALU. Accepts one decoded instruction and its operands via a valid/ready handshake, registers them, and drives the ALU's operand and `ld` inputs. For multi-cycle divides it waits for the ALU's `done`. It then captures the result and exception code and holds them on a tagged result port until the writeback stage acknowledges.

## Interface
Parameters:
- WID, 52, data width; matches `Data`.
- TAGW, 5, width of the result tag (ROB/physical-register id).
- TMO, 127, divide watchdog limit in cycles (used only with the watchdog macro).
- TMO_EXC, 8'h3F, exception code reported on watchdog expiry.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- in_valid, input, 1, upstream presents an instruction.
- in_ready, output, 1, sequencer can accept this cycle.
- in_op, input, `Instruction`, decoded instruction.
- in_a / in_b / in_imm, input, WID each, operands.
- in_big, input, 1, divide-enable mode bit.
- in_tag, input, TAGW, destination tag.
- alu_ld, output, 1, one-cycle load strobe to the ALU.
- alu_op, output, `Instruction`, registered instruction.
- alu_a / alu_b / alu_imm, output, WID each, registered operands.
- alu_big, output, 1, registered mode bit.
- alu_o, input, WID, ALU result.
- alu_done, input, 1, ALU completion.
- alu_exc, input, 8, ALU exception code.
- res_valid, output, 1, result held for writeback.
- res_ack, input, 1, writeback accepts the result.
- res_tag, output, TAGW, tag of the held result.
- res_o, output, WID, held result.
- res_exc, output, 8, held exception code.

## Operation
- States: IDLE, LOAD, WAIT, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid, register op, operands, big and tag, then go to LOAD.
- LOAD:
  - alu_ld=1 for exactly this cycle.
  - Non-DIV opcode: capture alu_o and alu_exc this cycle, then go to RESULT. The ALU is combinational for these.
  - DIV_3R: go to WAIT. alu_done is ignored in LOAD because it may be stale from the previous divide.
- WAIT:
  - On the first cycle with alu_done=1, capture alu_o and alu_exc, then go to RESULT.
- RESULT:
  - res_valid=1 with stable res_tag, res_o and res_exc until res_ack.
  - On res_ack with in_valid=0, go to IDLE.
  - On res_ack with in_valid=1, in_ready=1 in this cycle: the new instruction is registered and the next state is LOAD, so there is no bubble.
- in_ready = (state==IDLE) | (state==RESULT & res_ack).
- Operand registers change only on an accept. alu_a, alu_b, alu_imm and alu_op stay stable through WAIT.
- res_o and res_exc registers change only on capture.
- res_ack outside RESULT is ignored.

## Timing
- Reset values:
  - state=IDLE.
  - in_ready=1.
  - alu_ld=0.
  - res_valid=0.
  - All operand, tag, result and exception registers are 0.
- Reset mid-operation (any state) abandons the instruction with no result. The ALU's divider is reset by the same rst.
- Non-DIV latency: accept at T, ld at T+1, res_valid at T+2.
  - Sustained throughput with res_ack tied high: one result every 2 cycles.
- DIV latency: res_valid rises 1 cycle after the first alu_done=1 seen in WAIT.
- Simultaneous res_ack and in_valid in RESULT: the result retires and the new instruction is accepted in the same edge.

## Configuration
- ALU_DIV_WATCHDOG_EN:
  - Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If the counter reaches TMO with no alu_done, capture res_o=0 and res_exc=TMO_EXC, then go to RESULT.
  - Undefined: WAIT lasts until alu_done, with no counter logic present.

## Structure
- Shared package (Gambit types):
  - state enum type `AluSeqState`.
  - TMO_EXC default constant, beside the existing FLT_ codes.
- Opcodes are taken from Gambit-defines; `Instruction` and `Data` come from Gambit-types.
- No sub-module; the single FSM and its registers form one module.

## Test plan
- ADD_3R, a=5, b=7, res_ack=1: alu_ld pulses at T+1; res_valid at T+2 with res_o=12, res_exc=0, tag echoed.
- Back-to-back ORs with res_ack=1 and in_valid held high: a result every 2 cycles and in_ready=1 during every RESULT cycle.
- DIV_3R, big=1, 100/7 with done 20 cycles after ld: res_o=14, one cycle after done.
  - alu_ld is high for exactly one cycle.
  - alu_a and alu_b are stable throughout WAIT.
- res_ack held low 5 cycles in RESULT: res_valid, res_o and res_tag stay constant and in_ready=0. Retire on the 6th cycle.
- rst asserted during WAIT: the next cycle shows IDLE, res_valid=0, in_ready=1, and no late result after the divider finishes.
- With ALU_DIV_WATCHDOG_EN and alu_done held 0: res_valid after TMO WAIT cycles with res_exc=8'h3F and res_o=0.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
// Shared Gambit types for the ALU issue path: opcodes, data/instruction types,
// exception codes and the issue-sequencer state enum.
package alu_issue_seq_pkg;

  localparam int OP_W = 6;
  localparam int DATA_W = 52;

  typedef logic [OP_W-1:0]   Instruction;
  typedef logic [DATA_W-1:0] Data;

  localparam Instruction ADD_3R  = 6'h01;
  localparam Instruction SUB_3R  = 6'h02;
  localparam Instruction AND_3R  = 6'h03;
  localparam Instruction OR_3R   = 6'h04;
  localparam Instruction XOR_3R  = 6'h05;
  localparam Instruction ADDI_2R = 6'h06;
  localparam Instruction DIV_3R  = 6'h07;

  localparam logic [7:0] FLT_NONE     = 8'h00;
  localparam logic [7:0] FLT_DIVZ     = 8'h21;
  localparam logic [7:0] FLT_OVF      = 8'h22;
  localparam logic [7:0] TMO_EXC_DFLT = 8'h3F;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESULT} AluSeqState;

endpackage

// File: rtl/alu_issue_seq.sv
// Issue sequencer in front of the integer ALU: latch one instruction, strobe the ALU,
// wait for divides, then hold the tagged result until writeback acks. ALU_DIV_WATCHDOG_EN adds a divide timeout.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int         WID     = 52,
  parameter int         TAGW    = 5,
  parameter int         TMO     = 127,
  parameter logic [7:0] TMO_EXC = TMO_EXC_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [WID-1:0]  in_a,
  input  logic [WID-1:0]  in_b,
  input  logic [WID-1:0]  in_imm,
  input  logic            in_big,
  input  logic [TAGW-1:0] in_tag,
  output logic            alu_ld,
  output logic [OP_W-1:0] alu_op,
  output logic [WID-1:0]  alu_a,
  output logic [WID-1:0]  alu_b,
  output logic [WID-1:0]  alu_imm,
  output logic            alu_big,
  input  logic [WID-1:0]  alu_o,
  input  logic            alu_done,
  input  logic [7:0]      alu_exc,
  output logic            res_valid,
  input  logic            res_ack,
  output logic [TAGW-1:0] res_tag,
  output logic [WID-1:0]  res_o,
  output logic [7:0]      res_exc
);

  AluSeqState      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [WID-1:0]  a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic            big_q, big_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [7:0]      exc_q, exc_d;
`ifdef ALU_DIV_WATCHDOG_EN
  logic [7:0]      cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    big_d    = big_q;
    tag_d    = tag_q;
    res_d    = res_q;
    exc_d    = exc_q;
`ifdef ALU_DIV_WATCHDOG_EN
    cnt_d    = cnt_q;
`endif
    in_ready = (state_q == IDLE) || ((state_q == RESULT) && res_ack);

    case (state_q)
      LOAD: begin
        // alu_done here may be left over from the previous divide, so DIV never captures in LOAD.
        if (op_q != DIV_3R) begin
          res_d   = alu_o;
          exc_d   = alu_exc;
          state_d = RESULT;
        end else begin
          state_d = WAIT;
`ifdef ALU_DIV_WATCHDOG_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      WAIT: begin
        if (alu_done) begin
          res_d   = alu_o;
          exc_d   = alu_exc;
          state_d = RESULT;
        end
`ifdef ALU_DIV_WATCHDOG_EN
        else if (cnt_q == 8'(TMO - 1)) begin
          res_d   = '0;
          exc_d   = TMO_EXC;
          state_d = RESULT;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
`endif
      end
      RESULT: begin
        if (res_ack) state_d = IDLE;
      end
      default: ;
    endcase

    // An accept in RESULT overrides the return to IDLE so back-to-back issue has no bubble.
    if (in_valid && in_ready) begin
      op_d    = in_op;
      a_d     = in_a;
      b_d     = in_b;
      imm_d   = in_imm;
      big_d   = in_big;
      tag_d   = in_tag;
      state_d = LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      big_q   <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      exc_q   <= '0;
`ifdef ALU_DIV_WATCHDOG_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      big_q   <= big_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
`ifdef ALU_DIV_WATCHDOG_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign alu_ld    = (state_q == LOAD);
  assign res_valid = (state_q == RESULT);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_imm   = imm_q;
  assign alu_big   = big_q;
  assign res_tag   = tag_q;
  assign res_o     = res_q;
  assign res_exc   = exc_q;

endmodule
